// File: rtl/ysyx_25030093_lsu.sv
// Multicycle load/store stage: one valid/ready memory request per op, then a valid/ready handoff to WBU.
// Optional feature macro LSU_MISALIGN_CHECK_EN: misaligned ops skip memory and raise out_err.
module ysyx_25030093_lsu #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        LSU_single,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       LSU_data,
    output logic              out_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [31:0]       mem_rdata
);

    localparam logic [3:0] OP_LB  = 4'b0001;
    localparam logic [3:0] OP_LH  = 4'b0010;
    localparam logic [3:0] OP_LW  = 4'b0011;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       lsu_data_q, lsu_data_d;
    logic [31:0]       load_result;
    logic [31:0]       store_data;
    logic [3:0]        store_mask;
    logic [7:0]        load_byte;
    logic [15:0]       load_half;

    function automatic logic is_load(input logic [3:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

`ifdef LSU_MISALIGN_CHECK_EN
    logic err_q, err_d;

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lo);
        logic mis;
        mis = 1'b0;
        if (op inside {OP_LH, OP_LHU, OP_SH}) mis = lo[0];
        else if (op inside {OP_LW, OP_SW}) mis = (lo != 2'b00);
        return mis;
    endfunction

    assign out_err = err_q;
`else
    assign out_err = 1'b0;
`endif

    // Lane selection uses only the low address bits; misaligned bits are simply ignored here.
    always_comb begin
        load_byte   = 8'h00;
        load_half   = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_result = 32'h0;
        case (addr_q[1:0])
            2'b00:   load_byte = mem_rdata[7:0];
            2'b01:   load_byte = mem_rdata[15:8];
            2'b10:   load_byte = mem_rdata[23:16];
            default: load_byte = mem_rdata[31:24];
        endcase
        case (op_q)
            OP_LB:   load_result = {{24{load_byte[7]}}, load_byte};
            OP_LBU:  load_result = {24'h0, load_byte};
            OP_LH:   load_result = {{16{load_half[15]}}, load_half};
            OP_LHU:  load_result = {16'h0, load_half};
            OP_LW:   load_result = mem_rdata;
            default: load_result = 32'h0;
        endcase
    end

    always_comb begin
        store_data = wdata_q;
        store_mask = 4'b0000;
        case (op_q)
            OP_SB: begin
                store_data = {4{wdata_q[7:0]}};
                store_mask = 4'b0001 << addr_q[1:0];
            end
            OP_SH: begin
                store_data = {2{wdata_q[15:0]}};
                store_mask = addr_q[1] ? 4'b1100 : 4'b0011;
            end
            OP_SW: begin
                store_data = wdata_q;
                store_mask = 4'b1111;
            end
            default: begin
                store_data = wdata_q;
                store_mask = 4'b0000;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        lsu_data_d = lsu_data_q;
`ifdef LSU_MISALIGN_CHECK_EN
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d       = LSU_single;
                    addr_d     = addr;
                    wdata_d    = wdata;
                    lsu_data_d = 32'h0;
                    if (!(is_load(LSU_single) || is_store(LSU_single))) begin
                        state_d = S_DONE;
                    end
`ifdef LSU_MISALIGN_CHECK_EN
                    else if (is_misaligned(LSU_single, addr[1:0])) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end
`endif
                    else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem_req_ready) state_d = S_WAIT;
            end
            // A response arriving during the request handshake is never seen: WAIT is entered only afterwards.
            S_WAIT: begin
                if (mem_resp_valid) begin
                    state_d    = S_DONE;
                    lsu_data_d = is_load(op_q) ? load_result : 32'h0;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
`ifdef LSU_MISALIGN_CHECK_EN
                    err_d   = 1'b0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= 4'b0000;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            lsu_data_q <= 32'h0;
`ifdef LSU_MISALIGN_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            lsu_data_q <= lsu_data_d;
`ifdef LSU_MISALIGN_CHECK_EN
            err_q      <= err_d;
`endif
        end
    end

    assign in_ready      = (state_q == S_IDLE);
    assign out_valid     = (state_q == S_DONE);
    assign LSU_data      = lsu_data_q;
    assign mem_req_valid = (state_q == S_REQ);
    assign mem_wen       = (state_q == S_REQ) && is_store(op_q);
    assign mem_addr      = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wdata     = store_data;
    assign mem_wmask     = (state_q == S_REQ) ? store_mask : 4'b0000;

endmodule

// File: tb/tb_ysyx_25030093_lsu.sv
// Directed bench for ysyx_25030093_lsu: a vector table of complete ops plus hand-written
// sequences for backpressure, reset mid-transaction and stray responses.
module tb_ysyx_25030093_lsu;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  LSU_single;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] LSU_data;
    logic        out_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;

    int checks;
    int failures;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          exp_req;
        logic [31:0] exp_maddr;
        logic [31:0] exp_mwdata;
        logic [3:0]  exp_wmask;
        bit          exp_wen;
        logic [31:0] exp_data;
        bit          exp_err;
    } vec_t;

    vec_t vecs[$];

    ysyx_25030093_lsu #(.ADDR_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .addr          (addr),
        .wdata         (wdata),
        .LSU_single    (LSU_single),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .LSU_data      (LSU_data),
        .out_err       (out_err),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_wen       (mem_wen),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_resp_valid(mem_resp_valid),
        .mem_rdata     (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkVec(input string n, input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] wd, input logic [31:0] rd, input bit req,
                                   input logic [31:0] maddr, input logic [31:0] mwd,
                                   input logic [3:0] wm, input bit wen, input logic [31:0] d,
                                   input bit err);
        vec_t v;
        v.name = n; v.op = op; v.addr = a; v.wdata = wd; v.rdata = rd; v.exp_req = req;
        v.exp_maddr = maddr; v.exp_mwdata = mwd; v.exp_wmask = wm; v.exp_wen = wen;
        v.exp_data = d; v.exp_err = err;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Brings the DUT back to IDLE if an earlier faulty step left it stuck elsewhere.
    task automatic recover();
        if (in_ready !== 1'b1) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
        end
    endtask

    // Runs one complete op with a zero-wait memory and checks every visible effect.
    task automatic applyStimulus(input vec_t v);
        in_valid   = 1'b1;
        LSU_single = v.op;
        addr       = v.addr;
        wdata      = v.wdata;
        tick();
        in_valid   = 1'b0;
        LSU_single = 4'b0000;
        checkOutput({v.name, "_req_valid"}, 32'(mem_req_valid), 32'(v.exp_req));
        if (v.exp_req) begin
            checkOutput({v.name, "_mem_addr"}, mem_addr, v.exp_maddr);
            checkOutput({v.name, "_mem_wen"}, 32'(mem_wen), 32'(v.exp_wen));
            checkOutput({v.name, "_mem_wmask"}, 32'(mem_wmask), 32'(v.exp_wmask));
            if (v.exp_wen) checkOutput({v.name, "_mem_wdata"}, mem_wdata, v.exp_mwdata);
            mem_req_ready = 1'b1;
            tick();
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b1;
            mem_rdata      = v.rdata;
            tick();
            mem_resp_valid = 1'b0;
            mem_rdata      = 32'h0;
        end
        checkOutput({v.name, "_out_valid"}, 32'(out_valid), 32'd1);
        checkOutput({v.name, "_lsu_data"}, LSU_data, v.exp_data);
        checkOutput({v.name, "_out_err"}, 32'(out_err), 32'(v.exp_err));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput({v.name, "_back_idle"}, 32'(in_ready), 32'd1);
        checkOutput({v.name, "_out_valid_clr"}, 32'(out_valid), 32'd0);
        recover();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1; in_valid = 1'b0; addr = 32'h0; wdata = 32'h0; LSU_single = 4'b0000;
        out_ready = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0;

        vecs.push_back(mkVec("lb_neg",  4'b0001, 32'h8000_0003, 32'h0, 32'h80FF_1234, 1, 32'h8000_0000, 32'h0, 4'b0000, 0, 32'hFFFF_FF80, 0));
        vecs.push_back(mkVec("lbu",     4'b0100, 32'h8000_0003, 32'h0, 32'h80FF_1234, 1, 32'h8000_0000, 32'h0, 4'b0000, 0, 32'h0000_0080, 0));
        vecs.push_back(mkVec("none",    4'b0000, 32'h8000_0000, 32'h0, 32'h0,         0, 32'h0,         32'h0, 4'b0000, 0, 32'h0,         0));
        vecs.push_back(mkVec("lh_hi",   4'b0010, 32'h8000_0002, 32'h0, 32'h80FF_1234, 1, 32'h8000_0000, 32'h0, 4'b0000, 0, 32'hFFFF_80FF, 0));
        vecs.push_back(mkVec("lhu_lo",  4'b0101, 32'h8000_0000, 32'h0, 32'h80FF_1234, 1, 32'h8000_0000, 32'h0, 4'b0000, 0, 32'h0000_1234, 0));
        vecs.push_back(mkVec("lw",      4'b0011, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 1, 32'h8000_0004, 32'h0, 4'b0000, 0, 32'hDEAD_BEEF, 0));
        vecs.push_back(mkVec("undef",   4'b0111, 32'h8000_0004, 32'h0, 32'h0,         0, 32'h0,         32'h0, 4'b0000, 0, 32'h0,         0));
        vecs.push_back(mkVec("lb_b1",   4'b0001, 32'h8000_0001, 32'h0, 32'h80FF_1234, 1, 32'h8000_0000, 32'h0, 4'b0000, 0, 32'h0000_0012, 0));
        vecs.push_back(mkVec("sh_hi",   4'b1001, 32'h8000_0002, 32'h0000_BEEF, 32'h5555_5555, 1, 32'h8000_0000, 32'hBEEF_BEEF, 4'b1100, 1, 32'h0, 0));
        vecs.push_back(mkVec("sb_b1",   4'b1000, 32'h8000_0001, 32'h0000_00A5, 32'h5555_5555, 1, 32'h8000_0000, 32'hA5A5_A5A5, 4'b0010, 1, 32'h0, 0));
        vecs.push_back(mkVec("sb_b3",   4'b1000, 32'h8000_0003, 32'h1122_3344, 32'h5555_5555, 1, 32'h8000_0000, 32'h4444_4444, 4'b1000, 1, 32'h0, 0));
        vecs.push_back(mkVec("sw",      4'b1010, 32'h8000_0008, 32'h1234_5678, 32'h5555_5555, 1, 32'h8000_0008, 32'h1234_5678, 4'b1111, 1, 32'h0, 0));
        vecs.push_back(mkVec("lhu_hi",  4'b0101, 32'h8000_0002, 32'h0, 32'hABCD_0000, 1, 32'h8000_0000, 32'h0, 4'b0000, 0, 32'h0000_ABCD, 0));
`ifdef LSU_MISALIGN_CHECK_EN
        vecs.push_back(mkVec("lw_mis",  4'b0011, 32'h8000_0002, 32'h0, 32'hCAFE_F00D, 0, 32'h0,         32'h0, 4'b0000, 0, 32'h0,         1));
        vecs.push_back(mkVec("sh_mis",  4'b1001, 32'h8000_0001, 32'h0000_BEEF, 32'h0, 0, 32'h0,       32'h0, 4'b0000, 0, 32'h0,         1));
`else
        vecs.push_back(mkVec("lw_mis",  4'b0011, 32'h8000_0002, 32'h0, 32'hCAFE_F00D, 1, 32'h8000_0000, 32'h0, 4'b0000, 0, 32'hCAFE_F00D, 0));
        vecs.push_back(mkVec("sh_mis",  4'b1001, 32'h8000_0001, 32'h0000_BEEF, 32'h0, 1, 32'h8000_0000, 32'hBEEF_BEEF, 4'b0011, 1, 32'h0, 0));
`endif

        tick();
        tick();
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_req_valid", 32'(mem_req_valid), 32'd0);
        checkOutput("rst_lsu_data", LSU_data, 32'h0);
        checkOutput("rst_out_err", 32'(out_err), 32'd0);
        checkOutput("rst_mem_wen", 32'(mem_wen), 32'd0);
        checkOutput("rst_mem_wmask", 32'(mem_wmask), 32'd0);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Request backpressure, a response coinciding with the handshake, then output backpressure.
        in_valid = 1'b1; LSU_single = 4'b0011; addr = 32'h8000_0010;
        tick();
        in_valid = 1'b0; LSU_single = 4'b0000; addr = 32'h0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp_req_valid", 32'(mem_req_valid), 32'd1);
            checkOutput("bp_req_addr", mem_addr, 32'h8000_0010);
            tick();
        end
        checkOutput("bp_req_valid_last", 32'(mem_req_valid), 32'd1);
        mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'h1111_1111;
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        checkOutput("early_resp_out_valid", 32'(out_valid), 32'd0);
        checkOutput("wait_req_valid", 32'(mem_req_valid), 32'd0);
        tick();
        checkOutput("wait_idle_out_valid", 32'(out_valid), 32'd0);
        mem_resp_valid = 1'b1; mem_rdata = 32'h0BAD_F00D;
        tick();
        mem_resp_valid = 1'b0; mem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_lsu_data", LSU_data, 32'h0BAD_F00D);
            checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
            if (i < 2) tick();
        end
        out_ready = 1'b1; in_valid = 1'b1; LSU_single = 4'b0011; addr = 32'h8000_0020;
        tick();
        out_ready = 1'b0; in_valid = 1'b0; LSU_single = 4'b0000;
        checkOutput("no_reaccept_in_ready", 32'(in_ready), 32'd1);
        checkOutput("no_reaccept_req", 32'(mem_req_valid), 32'd0);
        checkOutput("no_reaccept_out_valid", 32'(out_valid), 32'd0);
        recover();

        // A response with nothing outstanding is ignored.
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        checkOutput("stray_idle_out_valid", 32'(out_valid), 32'd0);
        checkOutput("stray_idle_in_ready", 32'(in_ready), 32'd1);

        // Reset while waiting for a response drops the op; the late response must not revive it.
        in_valid = 1'b1; LSU_single = 4'b0001; addr = 32'h8000_0003;
        tick();
        in_valid = 1'b0; LSU_single = 4'b0000;
        checkOutput("rstwait_req_valid", 32'(mem_req_valid), 32'd1);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rstwait_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rstwait_out_valid", 32'(out_valid), 32'd0);
        mem_resp_valid = 1'b1; mem_rdata = 32'h80FF_1234;
        tick();
        mem_resp_valid = 1'b0;
        checkOutput("rstwait_late_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rstwait_late_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rstwait_lsu_data", LSU_data, 32'h0);
        tick();
        checkOutput("rstwait_still_idle", 32'(out_valid), 32'd0);

        // Reset while a store request is pending withdraws it.
        in_valid = 1'b1; LSU_single = 4'b1010; addr = 32'h8000_0030; wdata = 32'hCAFE_BABE;
        tick();
        in_valid = 1'b0; LSU_single = 4'b0000;
        checkOutput("rstreq_wen", 32'(mem_wen), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rstreq_req_valid", 32'(mem_req_valid), 32'd0);
        checkOutput("rstreq_wen_clr", 32'(mem_wen), 32'd0);
        checkOutput("rstreq_wmask_clr", 32'(mem_wmask), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
